// File: rtl/divi_u48_u24_arb.sv
// divi_u48_u24_arb: round-robin front end for one shared pipelined 48/24 divider.
// Tracks result owners in a tag pipe and returns results through a show-ahead FIFO.
// Optional feature macro: DIV_ZERO_FLAG_EN adds resp_dz (divisor-was-zero flag).
module divi_u48_u24_arb #(
  parameter int NREQ       = 4,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_vld,
  output logic [NREQ-1:0]    req_rdy,
  input  logic [NREQ*48-1:0] req_a,
  input  logic [NREQ*24-1:0] req_b,
  output logic               div_en,
  output logic               div_vldin,
  output logic [47:0]        div_ain,
  output logic [23:0]        div_bin,
  input  logic               div_vldout,
  input  logic [47:0]        div_out,
  input  logic [22:0]        div_rem,
  output logic               resp_vld,
  input  logic               resp_rdy,
  output logic [IDW-1:0]     resp_id,
  output logic [47:0]        resp_q,
  output logic [22:0]        resp_r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               resp_dz
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  // Circular pointer advance for FIFO depths that need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [IDW-1:0] rr_ptr, grant, idx;
  logic           found, can_issue, handshake, push, pop, bypass;
  logic [CW-1:0]  inflight, cnt, cnt_after_pop, cnt_next;
  logic [SW-1:0]  credit_sum;
  logic [PW-1:0]  wptr, rptr, rptr_next;
  logic [LAT-1:0] tag_vld;
  logic [IDW-1:0] tag_id [LAT];
  logic [IDW-1:0] mem_id [FIFO_DEPTH];
  logic [47:0]    mem_q  [FIFO_DEPTH];
  logic [22:0]    mem_r  [FIFO_DEPTH];
`ifdef DIV_ZERO_FLAG_EN
  logic [LAT-1:0]        tag_dz;
  logic [FIFO_DEPTH-1:0] mem_dz;
`endif

  // div_vldout is not trusted: the divider's valid chain is unreset garbage after rst.
  logic unused_vldout;
  assign unused_vldout = div_vldout;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        grant = idx;
      end else begin
        found = found;
      end
    end
  end

  // Credit counts in-flight ops plus stored results; a same-cycle pop is not credited.
  assign credit_sum = SW'(inflight) + SW'(cnt);
  assign can_issue  = en && !rst && (credit_sum < SW'(FIFO_DEPTH));
  assign handshake  = found && can_issue;
  assign req_rdy    = handshake ? (NREQ'(1) << grant) : '0;
  assign div_en     = en;
  assign div_vldin  = handshake;
  assign div_ain    = handshake ? req_a[48*grant +: 48] : 48'd0;
  assign div_bin    = handshake ? req_b[24*grant +: 24] : 24'd0;

  // Round-robin pointer moves past the winner only when a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    end
  end

  // Tag pipe mirrors the divider pipeline and advances only with en.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
`ifdef DIV_ZERO_FLAG_EN
      tag_dz <= '0;
`endif
    end else if (en) begin
      tag_vld   <= {tag_vld[LAT-2:0], handshake};
      tag_id[0] <= grant;
      for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
`ifdef DIV_ZERO_FLAG_EN
      tag_dz <= {tag_dz[LAT-2:0], handshake && (div_bin == 24'd0)};
`endif
    end
  end

  assign push = en && tag_vld[LAT-1];
  assign pop  = resp_vld && resp_rdy;

  // In-flight count: +1 on issue, -1 on result push.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({handshake, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO bookkeeping; a push into an otherwise empty FIFO bypasses straight to the head.
  always_comb begin
    cnt_after_pop = cnt - CW'(pop);
    cnt_next      = cnt_after_pop + CW'(push);
    rptr_next     = pop ? ptr_inc(rptr) : rptr;
    bypass        = push && (cnt_after_pop == '0);
  end

  // FIFO storage write; contents need no reset since cnt gates every read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_id[wptr] <= tag_id[LAT-1];
      mem_q[wptr]  <= div_out;
      mem_r[wptr]  <= div_rem;
`ifdef DIV_ZERO_FLAG_EN
      mem_dz[wptr] <= tag_dz[LAT-1];
`endif
    end
  end

  // Pointers, occupancy and the registered show-ahead head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      resp_vld <= 1'b0;
      resp_id  <= '0;
      resp_q   <= 48'd0;
      resp_r   <= 23'd0;
`ifdef DIV_ZERO_FLAG_EN
      resp_dz  <= 1'b0;
`endif
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      rptr     <= rptr_next;
      cnt      <= cnt_next;
      resp_vld <= (cnt_next != '0);
      if (bypass) begin
        resp_id <= tag_id[LAT-1];
        resp_q  <= div_out;
        resp_r  <= div_rem;
`ifdef DIV_ZERO_FLAG_EN
        resp_dz <= tag_dz[LAT-1];
`endif
      end else if (cnt_next != '0) begin
        resp_id <= mem_id[rptr_next];
        resp_q  <= mem_q[rptr_next];
        resp_r  <= mem_r[rptr_next];
`ifdef DIV_ZERO_FLAG_EN
        resp_dz <= mem_dz[rptr_next];
`endif
      end
    end
  end
endmodule

// File: tb/tb_divi_u48_u24_arb.sv
// Directed bench for divi_u48_u24_arb with a behavioural 7-stage divider model.
module tb_divi_u48_u24_arb;
  logic         clk = 1'b0;
  logic         rst, en, resp_rdy;
  logic [3:0]   req_vld, req_rdy;
  logic [191:0] req_a;
  logic [95:0]  req_b;
  logic         div_en, div_vldin, div_vldout, resp_vld;
  logic [47:0]  div_ain, div_out, resp_q;
  logic [23:0]  div_bin;
  logic [22:0]  div_rem, resp_r;
  logic [1:0]   resp_id;
`ifdef DIV_ZERO_FLAG_EN
  logic         resp_dz;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int id; logic [47:0] a; logic [23:0] b; int cyc; } hs_t;
  typedef struct { int id; logic [47:0] q; logic [22:0] r; logic dz; int cyc; } rsp_t;
  hs_t  hs_q[$];
  rsp_t rsp_q[$];

  divi_u48_u24_arb dut (
    .clk(clk), .rst(rst), .en(en), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .div_en(div_en), .div_vldin(div_vldin),
    .div_ain(div_ain), .div_bin(div_bin), .div_vldout(div_vldout),
    .div_out(div_out), .div_rem(div_rem), .resp_vld(resp_vld),
    .resp_rdy(resp_rdy), .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r)
`ifdef DIV_ZERO_FLAG_EN
    , .resp_dz(resp_dz)
`endif
  );

  always #5 clk = ~clk;

  // Divider stand-in: 7 en-qualified stages, no reset, b==0 gives q=0 and r=a.
  logic        m_v [7];
  logic [47:0] m_a [7];
  logic [23:0] m_b [7];
  always @(posedge clk) begin
    if (div_en) begin
      for (int k = 6; k > 0; k--) begin
        m_v[k] <= m_v[k-1]; m_a[k] <= m_a[k-1]; m_b[k] <= m_b[k-1];
      end
      m_v[0] <= div_vldin; m_a[0] <= div_ain; m_b[0] <= div_bin;
    end
  end
  assign div_vldout = m_v[6];
  assign div_out = (m_b[6] == 24'd0) ? 48'd0 : m_a[6] / {24'd0, m_b[6]};
  assign div_rem = (m_b[6] == 24'd0) ? m_a[6][22:0] : 23'(m_a[6] % {24'd0, m_b[6]});

  // Monitor: log handshakes and consumed responses with their edge number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (req_vld[i] && req_rdy[i])
          hs_q.push_back('{i, req_a[48*i +: 48], req_b[24*i +: 24], cyc});
      if (resp_vld && resp_rdy) begin
`ifdef DIV_ZERO_FLAG_EN
        rsp_q.push_back('{int'(resp_id), resp_q, resp_r, resp_dz, cyc});
`else
        rsp_q.push_back('{int'(resp_id), resp_q, resp_r, 1'b0, cyc});
`endif
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_vld = 4'd0; en = 1'b1; resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hs_q.delete(); rsp_q.delete();
  endtask

  task automatic wait_hs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (hs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; resp_rdy = 1'b1; req_vld = 4'hF;
    req_a = '0; req_b = '0;
    req_a[47:0] = 48'd1234; req_b[23:0] = 24'd5;
    repeat (2) @(negedge clk);
    checks++; if (req_rdy !== 4'd0) begin errors++; $display("FAIL rst_req_rdy got %0h want 0", req_rdy); end
    checks++; if (div_vldin !== 1'b0) begin errors++; $display("FAIL rst_vldin got %0b want 0", div_vldin); end
    checks++; if ({resp_vld, resp_id, resp_q, resp_r} !== 74'd0) begin
      errors++; $display("FAIL rst_resp got vld=%0b id=%0d q=%0h r=%0h want all 0", resp_vld, resp_id, resp_q, resp_r); end
`ifdef DIV_ZERO_FLAG_EN
    checks++; if (resp_dz !== 1'b0) begin errors++; $display("FAIL rst_dz got %0b want 0", resp_dz); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %0h want 1", req_rdy); end
    checks++; if (div_ain !== 48'd1234 || div_bin !== 24'd5) begin
      errors++; $display("FAIL rst_mux got a=%0d b=%0d want 1234 5", div_ain, div_bin); end
    @(negedge clk);
    req_vld = 4'd0;
    #1;
    checks++; if (div_vldin !== 1'b0 || div_ain !== 48'd0) begin
      errors++; $display("FAIL idle_mux got v=%0b a=%0d want 0 0", div_vldin, div_ain); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_a[48*1 +: 48] = 48'd100; req_b[24*1 +: 24] = 24'd7; req_vld = 4'b0010;
    wait_hs(1, ok); req_vld = 4'd0;
    wait_rsp(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got 0 responses want 1"); end
    else begin
      checks++; if (rsp_q[0].id !== 1) begin errors++; $display("FAIL single_id got %0d want 1", rsp_q[0].id); end
      checks++; if (rsp_q[0].q !== 48'd14 || rsp_q[0].r !== 23'd2) begin
        errors++; $display("FAIL single_qr got q=%0d r=%0d want 14 2", rsp_q[0].q, rsp_q[0].r); end
      checks++; if (rsp_q[0].cyc - hs_q[0].cyc !== 8) begin
        errors++; $display("FAIL single_latency got %0d want 8", rsp_q[0].cyc - hs_q[0].cyc); end
    end
  endtask

  logic [47:0] ta [4] = '{48'd1000, 48'd1001, 48'd50, 48'd77};
  logic [23:0] tb_ [4] = '{24'd10, 24'd3, 24'd6, 24'd77};
  logic [47:0] eq [4] = '{48'd100, 48'd333, 48'd8, 48'd1};
  logic [22:0] er [4] = '{23'd0, 23'd2, 23'd2, 23'd0};

  task automatic load_all();
    for (int i = 0; i < 4; i++) begin
      req_a[48*i +: 48] = ta[i]; req_b[24*i +: 24] = tb_[i];
    end
  endtask

  task automatic test_round_robin();
    bit ok; int bad_g, bad_r;
    do_reset();
    load_all(); req_vld = 4'hF;
    wait_hs(8, ok); req_vld = 4'd0;
    wait_rsp(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d responses want 8", rsp_q.size()); end
    else begin
      bad_g = 0; bad_r = 0;
      for (int k = 0; k < 8; k++) begin
        if (hs_q[k].id != k % 4) bad_g++;
        if (rsp_q[k].id != k % 4 || rsp_q[k].q !== eq[k%4] || rsp_q[k].r !== er[k%4]) bad_r++;
      end
      checks++; if (bad_g != 0) begin errors++; $display("FAIL rr_grant_order got %0d wrong want 0", bad_g); end
      checks++; if (bad_r != 0) begin errors++; $display("FAIL rr_resp_order got %0d wrong want 0", bad_r); end
      checks++; if (hs_q.size() != 8) begin errors++; $display("FAIL rr_hs_count got %0d want 8", hs_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int bad;
    do_reset();
    resp_rdy = 1'b0; load_all(); req_vld = 4'hF;
    repeat (20) @(negedge clk);
    checks++; if (hs_q.size() != 8) begin errors++; $display("FAIL bp_fill got %0d want 8", hs_q.size()); end
    checks++; if (req_rdy !== 4'd0 || resp_vld !== 1'b1) begin
      errors++; $display("FAIL bp_stall got rdy=%0h vld=%0b want 0 1", req_rdy, resp_vld); end
    resp_rdy = 1'b1;
    wait_hs(10, ok); req_vld = 4'd0;
    wait_rsp(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d responses want 10", rsp_q.size()); end
    else begin
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (rsp_q[k].id != k % 4 || rsp_q[k].q !== eq[k%4] || rsp_q[k].r !== er[k%4]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_drain_order got %0d wrong want 0", bad); end
      checks++; if (hs_q[8].cyc - rsp_q[0].cyc != 1 || hs_q[8].id != 0) begin
        errors++; $display("FAIL bp_resume got dt=%0d id=%0d want 1 0", hs_q[8].cyc - rsp_q[0].cyc, hs_q[8].id); end
    end
  endtask

  task automatic test_en_toggle();
    bit ok;
    do_reset();
    req_a[48*2 +: 48] = 48'd200; req_b[24*2 +: 24] = 24'd9;
    req_a[48*3 +: 48] = 48'd81;  req_b[24*3 +: 24] = 24'd4;
    req_vld = 4'b1100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hs_q.size() >= 2) req_vld = 4'd0;
      en = ~en;
    end
    en = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (hs_q.size() != 2 || rsp_q.size() != 2) begin
      errors++; $display("FAIL en_count got hs=%0d rsp=%0d want 2 2", hs_q.size(), rsp_q.size()); end
    else begin
      checks++; if (rsp_q[0].id != 2 || rsp_q[0].q !== 48'd22 || rsp_q[0].r !== 23'd2) begin
        errors++; $display("FAIL en_rsp0 got id=%0d q=%0d r=%0d want 2 22 2", rsp_q[0].id, rsp_q[0].q, rsp_q[0].r); end
      checks++; if (rsp_q[1].id != 3 || rsp_q[1].q !== 48'd20 || rsp_q[1].r !== 23'd1) begin
        errors++; $display("FAIL en_rsp1 got id=%0d q=%0d r=%0d want 3 20 1", rsp_q[1].id, rsp_q[1].q, rsp_q[1].r); end
      checks++; if (rsp_q[0].cyc - hs_q[0].cyc != 15 || rsp_q[1].cyc - hs_q[1].cyc != 15) begin
        errors++; $display("FAIL en_latency got %0d %0d want 15 15",
                           rsp_q[0].cyc - hs_q[0].cyc, rsp_q[1].cyc - hs_q[1].cyc); end
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    do_reset();
    load_all(); req_vld = 4'b0111;
    wait_hs(3, ok); req_vld = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (resp_vld !== 1'b0 || req_rdy !== 4'd0) begin
      errors++; $display("FAIL rstmid_clear got vld=%0b rdy=%0h want 0 0", resp_vld, req_rdy); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL rstmid_ghost got %0d responses want 0", rsp_q.size()); end
    hs_q.delete();
    req_a[47:0] = 48'hFFFF_FFFF_FFFF; req_b[23:0] = 24'd1; req_vld = 4'b0001;
    wait_hs(1, ok); req_vld = 4'd0;
    wait_rsp(1, ok);
    checks++; if (!ok || rsp_q.size() != 1) begin errors++; $display("FAIL rstmid_timeout got %0d responses want 1", rsp_q.size()); end
    else begin
      checks++; if (rsp_q[0].id != 0 || rsp_q[0].q !== 48'hFFFF_FFFF_FFFF || rsp_q[0].r !== 23'd0) begin
        errors++; $display("FAIL rstmid_max got id=%0d q=%0h r=%0d want 0 ffffffffffff 0", rsp_q[0].id, rsp_q[0].q, rsp_q[0].r); end
    end
  endtask

  task automatic test_div_zero();
    bit ok;
    do_reset();
    req_a[48*1 +: 48] = 48'd5; req_b[24*1 +: 24] = 24'd0; req_vld = 4'b0010;
    wait_hs(1, ok); req_vld = 4'd0;
    req_a[48*1 +: 48] = 48'd9; req_b[24*1 +: 24] = 24'd3; req_vld = 4'b0010;
    wait_hs(2, ok); req_vld = 4'd0;
    wait_rsp(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dz_timeout got %0d responses want 2", rsp_q.size()); end
    else begin
      checks++; if (rsp_q[0].q !== 48'd0 || rsp_q[0].r !== 23'd5) begin
        errors++; $display("FAIL dz_zero got q=%0d r=%0d want 0 5", rsp_q[0].q, rsp_q[0].r); end
      checks++; if (rsp_q[1].q !== 48'd3 || rsp_q[1].r !== 23'd0) begin
        errors++; $display("FAIL dz_next got q=%0d r=%0d want 3 0", rsp_q[1].q, rsp_q[1].r); end
`ifdef DIV_ZERO_FLAG_EN
      checks++; if (rsp_q[0].dz !== 1'b1 || rsp_q[1].dz !== 1'b0) begin
        errors++; $display("FAIL dz_flag got %0b %0b want 1 0", rsp_q[0].dz, rsp_q[1].dz); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; resp_rdy = 1'b1; req_vld = 4'd0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_en_toggle();
    test_rst_mid();
    test_div_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
